// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared state encoding, default timing and sizing helpers for the button debouncer
package button_debouncer_pkg;

  // Debouncer FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } btn_state_t;

  // Default timing constants in clock cycles
  localparam int unsigned DEF_DEBOUNCE_CLOCKS   = 6750000;
  localparam int unsigned DEF_LONG_PRESS_CLOCKS = 27000000;
  localparam int unsigned DEF_REPEAT_CLOCKS     = 6750000;

  // Largest of three values, used to size the shared counter width
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold 0..max_val, never less than one
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// rtl/button_debouncer_sync_2ff.sv - two-flop synchronizer with a configurable reset level
module sync_2ff #(
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both come out of reset at the idle level of the pin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - button debouncer with click, release, long-press and auto-repeat pulses
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CLOCKS   = DEF_DEBOUNCE_CLOCKS,
  parameter int unsigned LONG_PRESS_CLOCKS = DEF_LONG_PRESS_CLOCKS,
  parameter int unsigned REPEAT_CLOCKS     = DEF_REPEAT_CLOCKS,
  parameter bit          ACTIVE_LOW        = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic click,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int unsigned CW = cnt_width(max3(DEBOUNCE_CLOCKS, LONG_PRESS_CLOCKS, REPEAT_CLOCKS));

  // The cycle that leaves IDLE/PRESSED is the first stable sample, so the
  // debounce counter only has to cover the remaining DEBOUNCE_CLOCKS-1 samples.
  localparam bit          DEB_ONE   = (DEBOUNCE_CLOCKS == 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'((DEBOUNCE_CLOCKS >= 2) ? DEBOUNCE_CLOCKS - 2 : 0);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CLOCKS - 1);
  localparam logic [CW-1:0] LONG_CNT  = CW'(LONG_PRESS_CLOCKS);
  localparam logic [CW-1:0] REP_LAST  = CW'((REPEAT_CLOCKS >= 1) ? REPEAT_CLOCKS - 1 : 0);
  localparam logic [CW-1:0] CNT_SAT   = '1;
  localparam bit          REP_ON    = (REPEAT_CLOCKS != 0);

  logic       sync_q;
  logic       btn_sync;
  btn_state_t state;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] rep_cnt;

  sync_2ff #(
    .RESET_VALUE(ACTIVE_LOW)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_in),
    .q    (sync_q)
  );

  assign btn_sync = sync_q ^ ACTIVE_LOW;

  // Debounce FSM with hold/repeat timing; every output is a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      btn_level     <= 1'b0;
      click         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      click         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (btn_sync) begin
            deb_cnt <= '0;
            if (DEB_ONE) begin
              state     <= ST_PRESSED;
              btn_level <= 1'b1;
              click     <= 1'b1;
              hold_cnt  <= '0;
              rep_cnt   <= '0;
            end else begin
              state <= ST_DEB_PRESS;
            end
          end
        end
        ST_DEB_PRESS: begin
          if (!btn_sync) begin
            state   <= ST_IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state     <= ST_PRESSED;
            btn_level <= 1'b1;
            click     <= 1'b1;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!btn_sync && DEB_ONE) begin
            // Release wins outright so no hold pulse can share its cycle
            state         <= ST_IDLE;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
          end else begin
            if (!btn_sync) begin
              state   <= ST_DEB_RELEASE;
              deb_cnt <= '0;
            end
            if (hold_cnt != CNT_SAT) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
            // hold_cnt only passes LONG_LAST once per press, and stays at or
            // above LONG_CNT afterwards (saturation is above LONG_CNT)
            if (hold_cnt == LONG_LAST) begin
              long_press <= 1'b1;
              rep_cnt    <= '0;
            end else if (REP_ON && (hold_cnt >= LONG_CNT)) begin
              if (rep_cnt == REP_LAST) begin
                repeat_pulse <= 1'b1;
                rep_cnt      <= '0;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
          end
        end
        ST_DEB_RELEASE: begin
          if (btn_sync) begin
            // Bounce back: hold and repeat counters resume where they froze
            state   <= ST_PRESSED;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state         <= ST_IDLE;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          deb_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - randomized self-checking bench for button_debouncer against a behavioural model
module tb_button_debouncer;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pressed = 1'b0;
  logic btn0, btn1, btn2;
  logic [2:0] lv, ck, rl, lp, rp;

  assign btn0 = pressed;
  assign btn1 = pressed;
  assign btn2 = ~pressed;

  always #5 clk = ~clk;

  button_debouncer #(.DEBOUNCE_CLOCKS(D), .LONG_PRESS_CLOCKS(L), .REPEAT_CLOCKS(R), .ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .reset(reset), .btn_in(btn0), .btn_level(lv[0]), .click(ck[0]),
    .release_pulse(rl[0]), .long_press(lp[0]), .repeat_pulse(rp[0]));
  button_debouncer #(.DEBOUNCE_CLOCKS(D), .LONG_PRESS_CLOCKS(L), .REPEAT_CLOCKS(0), .ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .reset(reset), .btn_in(btn1), .btn_level(lv[1]), .click(ck[1]),
    .release_pulse(rl[1]), .long_press(lp[1]), .repeat_pulse(rp[1]));
  button_debouncer #(.DEBOUNCE_CLOCKS(D), .LONG_PRESS_CLOCKS(L), .REPEAT_CLOCKS(R), .ACTIVE_LOW(1'b1)) u2 (
    .clk(clk), .reset(reset), .btn_in(btn2), .btn_level(lv[2]), .click(ck[2]),
    .release_pulse(rl[2]), .long_press(lp[2]), .repeat_pulse(rp[2]));

  // Behavioural model: raw samples delayed two edges, then a run-length rule
  typedef struct {
    bit h1, h2;
    bit level;
    int run;
    int t;
    bit o_lv, o_ck, o_rl, o_lp, o_rp;
  } model_t;

  model_t m5, m0, mrst;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int n_ck = 0, n_rl = 0, n_lp = 0, n_rep = 0, n_lp0 = 0, n_rep0 = 0;
  int ck_cyc = -1, rl_cyc = -1, lp_cyc = -1, lp0_cyc = -1;
  int rep_q[$];
  int t0;

  function automatic model_t step(input model_t m, input bit raw, input int rep);
    bit s;
    bit holding;
    s = m.h2;
    m.h2 = m.h1;
    m.h1 = raw;
    m.o_ck = 0; m.o_rl = 0; m.o_lp = 0; m.o_rp = 0;
    holding = m.level && (m.run == 0);
    if (s != m.level) m.run = m.run + 1;
    else m.run = 0;
    if (m.run == D) begin
      m.level = s;
      m.run = 0;
      m.t = 0;
      if (s) m.o_ck = 1;
      else m.o_rl = 1;
    end else if (holding) begin
      m.t = m.t + 1;
      if (m.t == L) m.o_lp = 1;
      else if (rep > 0 && m.t > L && ((m.t - L) % rep) == 0) m.o_rp = 1;
    end
    m.o_lv = m.level;
    return m;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_ev();
    n_ck = 0; n_rl = 0; n_lp = 0; n_rep = 0; n_lp0 = 0; n_rep0 = 0;
    ck_cyc = -1; rl_cyc = -1; lp_cyc = -1; lp0_cyc = -1;
    rep_q.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance the model on each edge and compare all three DUTs just after it
  initial begin
    mrst = '{default: 0};
    m5 = mrst;
    m0 = mrst;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        m5 = mrst;
        m0 = mrst;
      end else begin
        m5 = step(m5, pressed, R);
        m0 = step(m0, pressed, 0);
      end
      #1;
      if (m5.o_ck) begin n_ck++; ck_cyc = cyc; end
      if (m5.o_rl) begin n_rl++; rl_cyc = cyc; end
      if (m5.o_lp) begin n_lp++; lp_cyc = cyc; end
      if (m5.o_rp) begin n_rep++; rep_q.push_back(cyc); end
      if (m0.o_lp) begin n_lp0++; lp0_cyc = cyc; end
      if (m0.o_rp) n_rep0++;
      for (int i = 0; i < 3; i++) begin
        model_t e;
        e = (i == 1) ? m0 : m5;
        check($sformatf("u%0d btn_level", i), lv[i], e.o_lv);
        check($sformatf("u%0d click", i), ck[i], e.o_ck);
        check($sformatf("u%0d release", i), rl[i], e.o_rl);
        check($sformatf("u%0d long_press", i), lp[i], e.o_lp);
        check($sformatf("u%0d repeat", i), rp[i], e.o_rp);
      end
    end
  end

  // Directed scenarios with literal timing, then randomized segments
  initial begin
    reset = 1'b1;
    pressed = 1'b0;
    cycles(3);
    reset = 1'b0;
    cycles(2);

    // Clean press held 10 cycles past click, then release
    clr_ev();
    pressed = 1'b1; t0 = cyc;
    cycles(16);
    check_int("clean click cycle", ck_cyc - t0, 6);
    check_int("clean click count", n_ck, 1);
    check("clean level high", lv[0], 1'b1);
    pressed = 1'b0; t0 = cyc;
    cycles(12);
    check_int("clean release cycle", rl_cyc - t0, 6);
    check_int("clean release count", n_rl, 1);
    check("clean level low", lv[0], 1'b0);

    // Bounce: 3 high / 1 low three times, then low
    clr_ev();
    repeat (3) begin
      pressed = 1'b1; cycles(3);
      pressed = 1'b0; cycles(1);
    end
    cycles(12);
    check_int("bounce click count", n_ck, 0);
    check("bounce level", lv[0], 1'b0);

    // Long hold: long press, repeats, and the no-repeat instance
    clr_ev();
    pressed = 1'b1; t0 = cyc;
    cycles(45);
    check_int("hold click cycle", ck_cyc - t0, 6);
    check_int("hold long_press cycle", lp_cyc - t0, 26);
    check_int("hold repeat count", n_rep, 3);
    if (rep_q.size() >= 3) begin
      check_int("hold repeat 1", rep_q[0] - t0, 31);
      check_int("hold repeat 2", rep_q[1] - t0, 36);
      check_int("hold repeat 3", rep_q[2] - t0, 41);
    end
    check_int("norep long_press cycle", lp0_cyc - t0, 26);
    pressed = 1'b0;
    cycles(12);
    check_int("hold long_press count", n_lp, 1);
    check_int("norep repeat count", n_rep0, 0);

    // Two-cycle release glitch while pressed
    clr_ev();
    pressed = 1'b1; t0 = cyc;
    cycles(11);
    pressed = 1'b0; cycles(2);
    pressed = 1'b1; cycles(35);
    check_int("glitch release count", n_rl, 0);
    check("glitch level", lv[0], 1'b1);
    check_int("glitch long_press cycle", lp_cyc - t0, 28);
    pressed = 1'b0;
    cycles(12);

    // Reset during a held press
    pressed = 1'b1;
    cycles(16);
    check("pre-reset level", lv[0], 1'b1);
    reset = 1'b1;
    #1;
    check("reset level now", lv[0], 1'b0);
    check("reset level now al", lv[2], 1'b0);
    cycles(3);
    clr_ev();
    reset = 1'b0; t0 = cyc;
    cycles(12);
    check_int("post-reset click cycle", ck_cyc - t0, 6);
    check_int("post-reset click count", n_ck, 1);
    pressed = 1'b0;
    cycles(12);

    // Randomized segments, mixing bounces with long holds
    for (int s = 0; s < 160; s++) begin
      int len;
      pressed = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 8));
      cycles(len);
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
      end
    end
    pressed = 1'b0;
    cycles(15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
